// File: rtl/add_share_arbiter.sv
// Two requesters share one WIDTH-bit adder through a round-robin arbiter.
// Each requester has a private accumulator; results leave through a
// one-entry registered buffer tagged with the requester id.
module add_share_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_sum,
    output logic                 res_carry,
    output logic                 res_id
);

    localparam int unsigned N_REQ = 2;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ACC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic [WIDTH-1:0] acc_q [N_REQ];
    logic             prio_q;          // requester that wins the next tie

    logic             slot_free_c;
    logic [1:0]       grant_c;
    logic             gnt_id_c;
    logic             accept_c;
    op_e              op_c;
    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] acc_sel_c;
    logic [WIDTH-1:0] add_x_c;
    logic [WIDTH-1:0] add_y_c;
    logic [WIDTH:0]   add_s_c;
    logic [WIDTH-1:0] sum_nxt_c;
    logic             carry_nxt_c;

    // The buffer can take a new result if it is empty or draining this cycle.
    assign slot_free_c = !res_valid || res_ready;

    // Round-robin grant; nothing is granted during reset or while the buffer is blocked.
    always_comb begin
        grant_c  = 2'b00;
        gnt_id_c = 1'b0;
        if (rst_n && slot_free_c) begin
            case (req_valid)
                2'b01:   gnt_id_c = 1'b0;
                2'b10:   gnt_id_c = 1'b1;
                2'b11:   gnt_id_c = prio_q;
                default: gnt_id_c = 1'b0;
            endcase
            if (req_valid != 2'b00) begin
                grant_c[gnt_id_c] = 1'b1;
            end
        end
    end

    assign req_ready = grant_c;
    assign accept_c  = |grant_c;

    // Pick the granted requester's op, operands and accumulator.
    always_comb begin
        op_c      = gnt_id_c ? op_e'(req_op[3:2]) : op_e'(req_op[1:0]);
        a_c       = gnt_id_c ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        b_c       = gnt_id_c ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        acc_sel_c = acc_q[gnt_id_c];
    end

    // Single shared adder: ACC adds operand A to the accumulator, ADD adds A and B.
    always_comb begin
        add_x_c = (op_c == OP_ACC) ? acc_sel_c : a_c;
        add_y_c = (op_c == OP_ACC) ? a_c       : b_c;
        add_s_c = {1'b0, add_x_c} + {1'b0, add_y_c};
    end

    // Result value per operation.
    always_comb begin
        sum_nxt_c   = add_s_c[WIDTH-1:0];
        carry_nxt_c = add_s_c[WIDTH];
        case (op_c)
            OP_CLR: begin
                sum_nxt_c   = '0;
                carry_nxt_c = 1'b0;
            end
            OP_LOAD: begin
                sum_nxt_c   = a_c;
                carry_nxt_c = 1'b0;
            end
            default: ;
        endcase
    end

    // Output buffer: load on accept, otherwise clear valid on drain and hold data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= 1'b0;
        end else if (accept_c) begin
            res_valid <= 1'b1;
            res_sum   <= sum_nxt_c;
            res_carry <= carry_nxt_c;
            res_id    <= gnt_id_c;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Private accumulators; only the granted requester's register changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q[0] <= '0;
            acc_q[1] <= '0;
        end else if (accept_c) begin
            case (op_c)
                OP_ACC:  acc_q[gnt_id_c] <= add_s_c[WIDTH-1:0];
                OP_CLR:  acc_q[gnt_id_c] <= '0;
                OP_LOAD: acc_q[gnt_id_c] <= a_c;
                default: ;
            endcase
        end
    end

    // Tie priority passes to the other requester after every accepted op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (accept_c) begin
            prio_q <= ~gnt_id_c;
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Randomized and directed bench for add_share_arbiter against a transaction-level model.
module tb_add_share_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int MOD = 256;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [3:0]           req_op;
    logic [2*WIDTH-1:0]   req_a;
    logic [2*WIDTH-1:0]   req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [WIDTH-1:0]     res_sum;
    logic                 res_carry;
    logic                 res_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: buffer contents, accumulators, last granted requester.
    bit m_valid;
    int m_sum;
    int m_carry;
    int m_id;
    int m_acc [2];
    int m_last;

    // Values captured by step() for the tests to compare.
    logic [1:0]  obs_ready;
    logic [1:0]  exp_ready;
    logic [10:0] obs_res;
    logic [10:0] exp_res;

    add_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid  = 1'b0;
        m_sum    = 0;
        m_carry  = 0;
        m_id     = 0;
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_last   = 1;
    endtask

    function automatic logic [10:0] pack_model();
        return {m_valid, 1'(m_carry), 1'(m_id), 8'(m_sum)};
    endfunction

    // One clock: drive inputs, capture ready mid-cycle, capture outputs after the edge.
    task automatic step(input logic [1:0] v, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic rr);
        int g;
        int opi;
        int ai;
        int bi;
        int s;
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        res_ready = rr;
        g = -1;
        if (!m_valid || rr) begin
            if (v == 2'b11)   g = 1 - m_last;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        #3;
        obs_ready = req_ready;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            opi = (g == 0) ? int'(op[1:0]) : int'(op[3:2]);
            ai  = (g == 0) ? int'(a[7:0])  : int'(a[15:8]);
            bi  = (g == 0) ? int'(b[7:0])  : int'(b[15:8]);
            case (opi)
                0: begin s = ai + bi;      m_sum = s % MOD; m_carry = s / MOD; end
                1: begin s = m_acc[g] + ai; m_sum = s % MOD; m_carry = s / MOD; m_acc[g] = m_sum; end
                2: begin m_sum = 0; m_carry = 0; m_acc[g] = 0; end
                default: begin m_sum = ai; m_carry = 0; m_acc[g] = ai; end
            endcase
            m_valid = 1'b1;
            m_id    = g;
            m_last  = g;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        exp_res = pack_model();
        obs_res = {res_valid, res_carry, res_id, res_sum};
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({res_valid, res_carry, res_id, res_sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 000", {res_valid, res_carry, res_id, res_sum});
        end
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        rst_n = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_single_add();
        step(2'b01, 4'b0000, 16'h007F, 16'h0001, 1'b1);
        n_tests++;
        if (obs_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_add_ready: got %b want 01", obs_ready);
        end
        n_tests++;
        if (obs_res !== {1'b1, 1'b0, 1'b0, 8'h80}) begin
            n_fail++;
            $display("FAIL single_add_result: got %h want %h", obs_res, {1'b1, 1'b0, 1'b0, 8'h80});
        end
        step(2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b1);
        n_tests++;
        if (obs_res !== exp_res) begin
            n_fail++;
            $display("FAIL single_add_drain: got %h want %h", obs_res, exp_res);
        end
    endtask

    task automatic test_carry_wrap();
        logic [10:0] want [4];
        want[0] = {1'b1, 1'b0, 1'b1, 8'hF0};
        want[1] = {1'b1, 1'b1, 1'b1, 8'h10};
        want[2] = {1'b1, 1'b0, 1'b0, 8'h00};
        want[3] = {1'b1, 1'b0, 1'b1, 8'h10};
        step(2'b10, 4'b1100, 16'hF000, 16'h0000, 1'b1);
        obs_res = {res_valid, res_carry, res_id, res_sum};
        n_tests++;
        if (obs_res !== want[0]) begin n_fail++; $display("FAIL wrap_load: got %h want %h", obs_res, want[0]); end
        step(2'b10, 4'b0100, 16'h2000, 16'hFF00, 1'b1);
        n_tests++;
        if (obs_res !== want[1]) begin n_fail++; $display("FAIL wrap_acc: got %h want %h", obs_res, want[1]); end
        step(2'b01, 4'b0001, 16'h0000, 16'h0000, 1'b1);
        n_tests++;
        if (obs_res !== want[2]) begin n_fail++; $display("FAIL wrap_acc0_isolated: got %h want %h", obs_res, want[2]); end
        step(2'b10, 4'b0100, 16'h0000, 16'h0000, 1'b1);
        n_tests++;
        if (obs_res !== want[3]) begin n_fail++; $display("FAIL wrap_acc1_value: got %h want %h", obs_res, want[3]); end
        n_tests++;
        if (obs_res !== exp_res) begin n_fail++; $display("FAIL wrap_model: got %h want %h", obs_res, exp_res); end
    endtask

    task automatic test_contention();
        logic prev_id;
        prev_id = res_id;
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 4'b0000, 16'($urandom), 16'($urandom), 1'b1);
            n_tests++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL contention_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
            end
            n_tests++;
            if (obs_res !== exp_res) begin
                n_fail++;
                $display("FAIL contention_result[%0d]: got %h want %h", i, obs_res, exp_res);
            end
            n_tests++;
            if (res_id !== ~prev_id) begin
                n_fail++;
                $display("FAIL contention_toggle[%0d]: got %b want %b", i, res_id, ~prev_id);
            end
            prev_id = res_id;
        end
        step(2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [10:0] held;
        step(2'b01, 4'b0000, 16'h0012, 16'h0034, 1'b1);
        held = {res_valid, res_carry, res_id, res_sum};
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 4'b0000, 16'($urandom), 16'($urandom), 1'b0);
            n_tests++;
            if (obs_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL backpressure_ready[%0d]: got %b want 00", i, obs_ready);
            end
            n_tests++;
            if (obs_res !== held || obs_res !== exp_res) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got %h want %h", i, obs_res, exp_res);
            end
        end
        step(2'b10, 4'b0000, 16'h0300, 16'h0400, 1'b1);
        n_tests++;
        if (obs_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_refill_ready: got %b want 10", obs_ready);
        end
        n_tests++;
        if (obs_res !== {1'b1, 1'b0, 1'b1, 8'h07}) begin
            n_fail++;
            $display("FAIL backpressure_refill: got %h want %h", obs_res, {1'b1, 1'b0, 1'b1, 8'h07});
        end
        step(2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic test_clr();
        logic [7:0] want [5];
        logic [1:0] ops  [5];
        logic [7:0] av   [5];
        want[0] = 8'h05; want[1] = 8'h0A; want[2] = 8'h0F; want[3] = 8'h00; want[4] = 8'h01;
        ops[0]  = 2'b01; ops[1]  = 2'b01; ops[2]  = 2'b01; ops[3]  = 2'b10; ops[4]  = 2'b01;
        av[0]   = 8'h05; av[1]   = 8'h05; av[2]   = 8'h05; av[3]   = 8'hAA; av[4]   = 8'h01;
        step(2'b01, 4'b0010, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(2'b01, {2'b00, ops[i]}, {8'h00, av[i]}, 16'h00FF, 1'b1);
            n_tests++;
            if (obs_res !== {1'b1, 1'b0, 1'b0, want[i]}) begin
                n_fail++;
                $display("FAIL clr_seq[%0d]: got %h want %h", i, obs_res, {1'b1, 1'b0, 1'b0, want[i]});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));
            n_tests++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL random_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
            end
            n_tests++;
            if (obs_res !== exp_res) begin
                n_fail++;
                $display("FAIL random_result[%0d]: got %h want %h", i, obs_res, exp_res);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(2'b01, 4'b0011, 16'h0033, 16'h0000, 1'b1);
        step(2'b10, 4'b1100, 16'h5500, 16'h0000, 1'b1);
        step(2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b0);
        n_tests++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got %b want 1", res_valid);
        end
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({res_valid, res_carry, res_id, res_sum} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want 000", {res_valid, res_carry, res_id, res_sum});
        end
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b want 00", req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b11, 4'b0000, 16'h0102, 16'h0304, 1'b1);
        n_tests++;
        if (obs_res !== {1'b1, 1'b0, 1'b0, 8'h06}) begin
            n_fail++;
            $display("FAIL reset_mid_first_grant: got %h want %h", obs_res, {1'b1, 1'b0, 1'b0, 8'h06});
        end
        step(2'b01, 4'b0001, 16'h0000, 16'h0000, 1'b1);
        n_tests++;
        if (obs_res !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_acc0: got %h want %h", obs_res, {1'b1, 1'b0, 1'b0, 8'h00});
        end
        step(2'b10, 4'b0100, 16'h0000, 16'h0000, 1'b1);
        n_tests++;
        if (obs_res !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_acc1: got %h want %h", obs_res, {1'b1, 1'b0, 1'b1, 8'h00});
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_single_add();
        test_carry_wrap();
        test_contention();
        test_backpressure();
        test_clr();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one WIDTH-bit adder between two requesters using valid/ready handshakes and round-robin arbitration.
- Each requester owns a private accumulator register and can issue ADD, ACC, CLR or LOAD operations.
- Results go to a single consumer through a one-entry registered output buffer, tagged with the requester id.
- Sits between the pin-level I/O of the tt_um top and the adder datapath.

Parameters:
- WIDTH, 8, operand, accumulator and sum width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  bit i set: requester i presents an operation.
- req_ready  output  2  bit i set: requester i's operation is accepted this cycle.
- req_op  input  4  requester i op at [2i+:2]: 00 ADD, 01 ACC, 10 CLR, 11 LOAD.
- req_a  input  2*WIDTH  operand A, requester i at [i*WIDTH+:WIDTH].
- req_b  input  2*WIDTH  operand B, requester i at [i*WIDTH+:WIDTH]; used by ADD only.
- res_valid  output  1  output buffer holds a result.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  result value.
- res_carry  output  1  carry out of the addition.
- res_id  output  1  id of the requester that produced the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0.
  - acc0=acc1=0; round-robin pointer set so requester 0 has priority first.
  - req_ready=00 while rst_n is low.
  - Any buffered result is discarded; no partial state survives reset.
- Slot free:
  - slot_free = !res_valid | res_ready.
  - Drain and refill in the same cycle is legal, giving 1 op/cycle throughput when res_ready is held high.
- Arbitration (combinational):
  - Only while slot_free.
  - Exactly one valid requester: grant it.
  - Both valid: grant the requester not granted last.
  - Pointer updates only on an accepted op, never on idle cycles.
  - req_ready = grant, a one-hot or zero vector. It may depend combinationally on req_valid and res_ready. req_valid must not depend on req_ready.
- Accept: req_valid[i] & req_ready[i]. On the next rising edge:
  - res_valid=1, res_id=i, and res_sum/res_carry are loaded per op.
  - Latency from accept to visible result is 1 cycle.
- Operations (s is a (WIDTH+1)-bit sum):
  - ADD: s = a + b. res_sum = s[WIDTH-1:0], res_carry = s[WIDTH]. acc[i] unchanged.
  - ACC: s = acc[i] + a. res_sum = s[WIDTH-1:0], res_carry = s[WIDTH], acc[i] <= s[WIDTH-1:0] (wraps modulo 2^WIDTH). b is ignored.
  - CLR: acc[i] <= 0, res_sum = 0, res_carry = 0.
  - LOAD: acc[i] <= a, res_sum = a, res_carry = 0.
- Holding: when res_valid=1 and res_ready=0, res_sum, res_carry and res_id hold and no request is accepted (req_ready=00).
- Drain without refill: res_valid falls on the next edge; res_sum, res_carry and res_id hold their last values.
- Accumulator isolation: acc0 is touched only by requester 0 ops and acc1 only by requester 1 ops.
- Fairness: a requester holding req_valid high is accepted within 2 slot_free cycles.
- Structure: a single shared adder instance feeds the output register.

Test Plan:
- Reset then single ADD: req0 ADD a=0x7F b=0x01 with res_ready=1 -> 1 cycle later res_valid=1, res_sum=0x80, res_carry=0, res_id=0.
- Carry/wrap: req1 LOAD a=0xF0, then ACC a=0x20 -> results 0xF0/c=0, then 0x10/c=1; acc1=0x10; acc0 stays 0.
- Contention: both requesters hold ADD continuously, res_ready=1 -> grants alternate 0,1,0,1; res_id toggles every cycle; 1 result per cycle.
- Backpressure: res_ready=0 with a result buffered -> req_ready=00 for 5 cycles, outputs stable. Raise res_ready together with pending req1 -> drain and accept in the same cycle; next result has res_id=1.
- CLR after ACC: req0 ACC a=0x05 three times (results 0x05, 0x0A, 0x0F), then CLR -> res_sum=0, then ACC a=0x01 -> 0x01.
- Reset mid-operation: assert rst_n low while res_valid=1 and res_ready=0 -> res_valid=0 immediately (asynchronous), acc0=acc1=0; after release, requester 0 wins the first contention.
